// File: rtl/regfile_pkg.sv
// Shared types, default widths and the write-priority helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    // Upper bound on write ports the priority helper can arbitrate.
    localparam int unsigned MAX_WR = 16;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    // Highest set index wins; returns 0 when no bit is set (caller gates with |hits).
    function automatic int unsigned wr_winner(input logic [MAX_WR-1:0] hits);
        int unsigned win;
        win = 0;
        for (int unsigned j = 0; j < MAX_WR; j++) begin
            if (hits[j]) win = j;
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Matches one address against all write ports: hit, winning data and release flag.
module regfile_wr_sel import regfile_pkg::*; #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_WR = 2
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]        wr_rel_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     rel_o
);

    logic [MAX_WR-1:0] hits;
    int unsigned       win;

    // Collect matching ports, release if any matching port releases, data from the winner.
    always_comb begin
        hits  = '0;
        rel_o = 1'b0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == addr_i)) begin
                hits[j] = 1'b1;
                if (wr_rel_i[j]) rel_o = 1'b1;
            end
        end
        win    = wr_winner(hits);
        hit_o  = |hits;
        data_o = hit_o ? wr_data_i[win*DATA_W +: DATA_W] : '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, pending scoreboard and soft-clear engine.
module regfile_mp import regfile_pkg::*; #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_pend_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]        wr_rel_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;
    logic [DEPTH-1:0]               pend_q, pend_d;

    logic                           busy;
    logic [NUM_WR-1:0]              wr_en_g;
    logic                           iss_g;
    logic [DEPTH-1:0]               ent_hit, ent_rel;
    logic [DEPTH-1:0][DATA_W-1:0]   ent_data;

    // Everything from the pipeline is ignored while the clear sequence runs.
    assign busy       = (state_q == ST_CLEAR);
    assign clr_busy_o = busy;
    assign wr_en_g    = busy ? '0 : wr_en_i;
    assign iss_g      = iss_en_i & ~busy;

    for (genvar a = 0; a < DEPTH; a++) begin : g_ent
        regfile_wr_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_sel (
            .addr_i    (ADDR_W'(a)),
            .wr_en_i   (wr_en_g),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .wr_rel_i  (wr_rel_i),
            .hit_o     (ent_hit[a]),
            .data_o    (ent_data[a]),
            .rel_o     (ent_rel[a])
        );
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp_hit, byp_rel, blank, iss_same;
        logic [DATA_W-1:0] byp_data;

        assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

        regfile_wr_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_sel (
            .addr_i    (ra),
            .wr_en_i   (wr_en_g),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .wr_rel_i  (wr_rel_i),
            .hit_o     (byp_hit),
            .data_o    (byp_data),
            .rel_o     (byp_rel)
        );

        assign blank    = busy || (ZERO_REG && (ra == '0));
        assign iss_same = iss_g && (iss_addr_i == ra);
        assign rd_data_o[k*DATA_W +: DATA_W] = blank ? '0 : (byp_hit ? byp_data : mem_q[ra]);
        // A releasing write clears the flag early unless a younger producer issues alongside it.
        assign rd_pend_o[k] = !blank && pend_q[ra] && !(byp_rel && !iss_same);
    end

    // Next state: array/scoreboard updates in IDLE, one entry zeroed per cycle in CLEAR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                for (int a = 0; a < DEPTH; a++) begin
                    if (ent_hit[a]) mem_d[a] = ent_data[a];
                    if (ent_rel[a]) pend_d[a] = 1'b0;
                    if (iss_g && (iss_addr_i == ADDR_W'(a))) pend_d[a] = 1'b1;
                end
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    pend_d  = '0;
                end
            end
            ST_CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ZERO_REG) begin
            mem_d[0]  = '0;
            pend_d[0] = 1'b0;
        end
    end

    // State registers with asynchronous clear of the whole array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mem_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            pend_q  <= pend_d;
        end
    end

endmodule
